wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
// - Shares the single register-file write port among three write-back sources: ALU result, load return, link (jal).
// - Resolves the ALU destination from the rt/rd instruction fields via the 2-bit RegDst code.
// - Grants one source per cycle: fixed priority, with anti-starvation promotion.
// - Drives the register-file write port from registered outputs.
// - Sits between the execute/memory stages and the register file.
// PARAMETERS
// DATA_W        32       write data width
// ADDR_W        5        register address width
// RA_ADDR       5'd31    link register address
// STARVE_LIMIT  4        wait cycles before a requester is promoted to urgent (>=1)
// PORTS
// clock          in   1       system clock, rising edge
// reset          in   1       synchronous, active-high
// hold           in   1       1 = no grants this cycle (register file busy/stall)
// alu_req        in   1       ALU write-back request
// alu_rt         in   ADDR_W  instruction bits 20:16
// alu_rd         in   ADDR_W  instruction bits 15:11
// alu_regdst     in   2       00=rt, 01=rd, 10=RA_ADDR, 11=address 0
// alu_data       in   DATA_W  ALU result
// alu_ack        out  1       grant, combinational, same cycle
// ld_req         in   1       load write-back request
// ld_addr        in   ADDR_W  load destination
// ld_data        in   DATA_W  load data
// ld_ack         out  1       grant
// lnk_req        in   1       link write request (target RA_ADDR)
// lnk_data       in   DATA_W  return address (PC+4)
// lnk_ack        out  1       grant
// rf_we          out  1       register file write enable (registered)
// rf_waddr       out  ADDR_W  register file write address (registered)
// rf_wdata       out  DATA_W  register file write data (registered)
// last_grant     out  2       00=none, 01=alu, 10=ld, 11=lnk (registered, debug)
// BEHAVIOUR
// - Reset (sync, on clock edge with reset=1):
//   - rf_we=0, rf_waddr=0, rf_wdata=0, last_grant=00.
//   - All wait counters cleared.
//   - acks forced 0 while reset=1.
// - Handshake:
//   - Requester holds req and payload stable until its ack.
//   - ack is high for exactly the grant cycle.
//   - req dropping without ack is legal (request withdrawn, counter cleared).
// - Arbitration (combinational), at most one ack per cycle:
//   - hold=1 -> no ack.
//   - Otherwise urgent requesters win over non-urgent ones.
//   - Within a class, priority is ld > alu > lnk.
// - Urgency: per-requester counter.
//   - +1 each cycle req && !ack, including hold cycles.
//   - Saturates at STARVE_LIMIT.
//   - Cleared on ack or !req.
//   - Urgent when counter == STARVE_LIMIT.
// - Write latency: 1 cycle. At the edge after an ack:
//   - rf_we=1.
//   - rf_waddr/rf_wdata = granted payload.
//   - last_grant = granted source.
//   - No ack -> rf_we=0, last_grant=00; rf_waddr/rf_wdata hold previous values.
// - ALU address: decoded from alu_regdst as listed. Code 11 yields address 0.
// - Address 0: a grant whose address is 0 is acked normally but produces rf_we=0; last_grant is still updated.
// - lnk address is always RA_ADDR.
// - Simultaneous ld+alu+lnk with no urgency:
//   - ld granted first.
//   - alu next cycle.
//   - lnk third (unless promoted earlier).
// - Reset mid-operation: pending requests are not remembered; requesters re-present after reset falls.
// STRUCTURE
// - Shared package:
//   - RegDst codes (REGDST_RT=2'b00, REGDST_RD=2'b01, REGDST_RA=2'b10).
//   - RA_ADDR constant.
//   - Source codes GRANT_NONE/ALU/LD/LNK.
// - One sub-module: wb_starve_ctr (req, ack, hold-agnostic saturating counter, urgent output), instantiated 3x.
// - Arbiter, RegDst decode and output register stay in this module.
// TESTING
// - Reset with all req=1 -> all acks 0; after release, rf_we=0 and last_grant=00 before the first grant edge.
// - alu_req, regdst=01, rt=3, rd=9, data=0xA5 -> alu_ack same cycle; next cycle rf_we=1, waddr=9, wdata=0xA5, last_grant=01.
// - alu regdst=10 -> waddr=31; regdst=11 -> ack given, rf_we=0.
// - ld and alu every cycle, STARVE_LIMIT=4:
//   - ld acked in cycles 0-3.
//   - alu promoted and acked in cycle 4.
//   - ld resumes in cycle 5.
// - hold=1 for 6 cycles with lnk_req -> no ack, counter saturates; hold=0 -> lnk_ack; waddr=31, wdata=lnk_data.
// - Simultaneous ld+alu+lnk, no urgency -> grant order ld, alu, lnk over 3 cycles, one rf_we per cycle.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared constants for the write-back port arbiter
// Contents: RegDst decode codes, the link register address and the grant source
// codes that also appear on the last_grant debug output.
package wb_port_arbiter_pkg;

  // alu_regdst codes; 2'b11 selects register 0 (write suppressed)
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_RA   = 2'b10;
  localparam logic [1:0] REGDST_ZERO = 2'b11;

  localparam logic [4:0] RA_ADDR = 5'd31;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_ALU  = 2'b01,
    GRANT_LD   = 2'b10,
    GRANT_LNK  = 2'b11
  } grant_e;

endpackage

// File: rtl/wb_starve_ctr.sv
// rtl/wb_starve_ctr.sv - per-requester wait counter with urgent flag
// Ports:
//   clock   in  system clock, rising edge
//   reset   in  synchronous, active-high
//   req     in  requester is asking for the write port
//   ack     in  requester was granted this cycle
//   urgent  out counter has reached LIMIT
// Counts every cycle a request waits, hold cycles included, so a requester
// stalled behind hold still ages toward urgency.
module wb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic ack,
  output logic urgent
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || ack) begin
      cnt_d = '0;
    end else if (cnt_q != LIM) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign urgent = (cnt_q == LIM);

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter for ALU/load/link
// Ports:
//   clock, reset                    clock and synchronous active-high reset
//   hold                            suppresses all grants for the cycle
//   alu_req/rt/rd/regdst/data/ack   ALU write-back request, same-cycle ack
//   ld_req/addr/data/ack            load write-back request, same-cycle ack
//   lnk_req/data/ack                link write (to RA_ADDR), same-cycle ack
//   rf_we/rf_waddr/rf_wdata         registered register-file write port
//   last_grant                      registered source of the last grant
module wb_port_arbiter #(
  parameter int unsigned          DATA_W       = 32,
  parameter int unsigned          ADDR_W       = 5,
  parameter logic [ADDR_W-1:0]    RA_ADDR      = wb_port_arbiter_pkg::RA_ADDR,
  parameter int unsigned          STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic              alu_req,
  input  logic [ADDR_W-1:0] alu_rt,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [1:0]        alu_regdst,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ack,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  input  logic              lnk_req,
  input  logic [DATA_W-1:0] lnk_data,
  output logic              lnk_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [1:0]        last_grant
);

  import wb_port_arbiter_pkg::*;

  logic              alu_urgent, ld_urgent, lnk_urgent;
  grant_e            grant;
  logic [ADDR_W-1:0] alu_addr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              rf_we_d, rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_d, rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_d, rf_wdata_q;
  grant_e            last_grant_d, last_grant_q;

  wb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_alu_ctr (
    .clock(clock), .reset(reset), .req(alu_req), .ack(alu_ack), .urgent(alu_urgent)
  );
  wb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_ld_ctr (
    .clock(clock), .reset(reset), .req(ld_req), .ack(ld_ack), .urgent(ld_urgent)
  );
  wb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_lnk_ctr (
    .clock(clock), .reset(reset), .req(lnk_req), .ack(lnk_ack), .urgent(lnk_urgent)
  );

  always_comb begin
    alu_addr = '0;
    case (alu_regdst)
      REGDST_RT: alu_addr = alu_rt;
      REGDST_RD: alu_addr = alu_rd;
      REGDST_RA: alu_addr = RA_ADDR;
      default:   alu_addr = '0;
    endcase
  end

  // Urgent class first, then ld > alu > lnk. The urgent flag comes from the
  // previous cycle's count, so it is qualified with the live req in case the
  // requester has just withdrawn.
  always_comb begin
    grant = GRANT_NONE;
    if (!reset && !hold) begin
      if (ld_req && ld_urgent)        grant = GRANT_LD;
      else if (alu_req && alu_urgent) grant = GRANT_ALU;
      else if (lnk_req && lnk_urgent) grant = GRANT_LNK;
      else if (ld_req)                grant = GRANT_LD;
      else if (alu_req)               grant = GRANT_ALU;
      else if (lnk_req)               grant = GRANT_LNK;
    end
  end

  assign alu_ack = (grant == GRANT_ALU);
  assign ld_ack  = (grant == GRANT_LD);
  assign lnk_ack = (grant == GRANT_LNK);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    case (grant)
      GRANT_ALU: begin sel_addr = alu_addr; sel_data = alu_data; end
      GRANT_LD:  begin sel_addr = ld_addr;  sel_data = ld_data;  end
      GRANT_LNK: begin sel_addr = RA_ADDR;  sel_data = lnk_data; end
      default:   begin sel_addr = '0;       sel_data = '0;       end
    endcase
  end

  // Register 0 is hard-wired, so a grant to it is consumed without a write.
  always_comb begin
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    last_grant_d = GRANT_NONE;
    if (grant != GRANT_NONE) begin
      rf_we_d      = (sel_addr != '0);
      rf_waddr_d   = sel_addr;
      rf_wdata_d   = sel_data;
      last_grant_d = grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      last_grant_q <= GRANT_NONE;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset, hold;
  logic        alu_req, ld_req, lnk_req;
  logic [4:0]  alu_rt, alu_rd, ld_addr;
  logic [1:0]  alu_regdst;
  logic [31:0] alu_data, ld_data, lnk_data;
  logic        alu_ack, ld_ack, lnk_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  last_grant;

  always #5 clock = ~clock;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .RA_ADDR(5'd31), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .alu_req(alu_req), .alu_rt(alu_rt), .alu_rd(alu_rd), .alu_regdst(alu_regdst),
    .alu_data(alu_data), .alu_ack(alu_ack),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .lnk_req(lnk_req), .lnk_data(lnk_data), .lnk_ack(lnk_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .last_grant(last_grant)
  );

  typedef struct {
    logic        rst;
    logic        hold;
    logic        alu_req;
    logic [1:0]  regdst;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] alu_data;
    logic        ld_req;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        lnk_req;
    logic [31:0] lnk_data;
    logic [2:0]  exp_ack;   // {lnk, ld, alu}
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_last;
  } vec_t;

  vec_t vecs [13];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: sources 1=alu 2=ld 3=lnk (same numbers as last_grant)
  int          wait_cnt [4];
  int          rank [4];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [1:0]  m_last;
  logic [2:0]  m_ack;
  logic [2:0]  s_ack;

  int starve_seq [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ack_of(input int g);
    case (g)
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit req_of(input int s);
    case (s)
      1: return alu_req;
      2: return ld_req;
      3: return lnk_req;
      default: return 1'b0;
    endcase
  endfunction

  // winner = highest score, where waiting long enough adds a large bonus
  function automatic int model_grant();
    int best, best_score, sc;
    best = 0;
    best_score = 0;
    if (reset || hold) return 0;
    for (int s = 1; s <= 3; s++) begin
      if (req_of(s)) begin
        sc = rank[s] + ((wait_cnt[s] >= LIMIT) ? 10 : 0);
        if (sc > best_score) begin
          best_score = sc;
          best = s;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [4:0] model_dest(input int g);
    if (g == 2) return ld_addr;
    if (g == 3) return 5'd31;
    case (alu_regdst)
      2'd0: return alu_rt;
      2'd1: return alu_rd;
      2'd2: return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  task automatic model_update(input int g);
    if (reset) begin
      for (int s = 0; s < 4; s++) wait_cnt[s] = 0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_last = 2'b00;
      return;
    end
    for (int s = 1; s <= 3; s++) begin
      if (!req_of(s) || g == s) wait_cnt[s] = 0;
      else if (wait_cnt[s] < LIMIT) wait_cnt[s] = wait_cnt[s] + 1;
    end
    if (g == 0) begin
      m_we = 1'b0;
      m_last = 2'b00;
    end else begin
      m_last  = 2'(g);
      m_waddr = model_dest(g);
      m_wdata = (g == 1) ? alu_data : (g == 2) ? ld_data : lnk_data;
      m_we    = (m_waddr != 5'd0);
    end
  endtask

  // inputs are already driven; sample acks mid-cycle, outputs just after the edge
  task automatic tick();
    int g;
    @(negedge clock);
    g = model_grant();
    m_ack = ack_of(g);
    s_ack = {lnk_ack, ld_ack, alu_ack};
    @(posedge clock);
    #1;
    model_update(g);
  endtask

  task automatic idle();
    reset = 1'b0; hold = 1'b0;
    alu_req = 1'b0; ld_req = 1'b0; lnk_req = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; hold = v.hold;
    alu_req = v.alu_req; alu_regdst = v.regdst; alu_rt = v.rt; alu_rd = v.rd; alu_data = v.alu_data;
    ld_req = v.ld_req; ld_addr = v.ld_addr; ld_data = v.ld_data;
    lnk_req = v.lnk_req; lnk_data = v.lnk_data;
  endtask

  initial begin
    rank = '{0, 2, 3, 1};
    starve_seq = '{2, 2, 2, 2, 1, 2};
    for (int s = 0; s < 4; s++) wait_cnt[s] = 0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_last = 2'b00;
    reset = 1'b1; hold = 1'b0;
    alu_req = 1'b0; alu_regdst = 2'b00; alu_rt = '0; alu_rd = '0; alu_data = '0;
    ld_req = 1'b0; ld_addr = '0; ld_data = '0;
    lnk_req = 1'b0; lnk_data = '0;

    //           rst   hold  areq  rdst   rt     rd     adata         lreq  laddr  ldata         kreq  kdata          ack     we    waddr   wdata         last
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'b01, 5'd3,  5'd9,  32'h0000_0001, 1'b1, 5'd2,  32'h0000_0002, 1'b1, 32'h0000_0003, 3'b000, 1'b0, 5'd0,  32'h0000_0000, 2'b00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 3'b000, 1'b0, 5'd0,  32'h0000_0000, 2'b00};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'b01, 5'd3,  5'd9,  32'h0000_00A5, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 3'b001, 1'b1, 5'd9,  32'h0000_00A5, 2'b01};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'b10, 5'd3,  5'd9,  32'h0000_0011, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 3'b001, 1'b1, 5'd31, 32'h0000_0011, 2'b01};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'b11, 5'd3,  5'd9,  32'h0000_0022, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 3'b001, 1'b0, 5'd0,  32'h0000_0022, 2'b01};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'b00, 5'd3,  5'd9,  32'h0000_0033, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 3'b001, 1'b1, 5'd3,  32'h0000_0033, 2'b01};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  32'h0000_0000, 1'b1, 5'd7,  32'h0000_0044, 1'b0, 32'h0000_0000, 3'b010, 1'b1, 5'd7,  32'h0000_0044, 2'b10};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 32'h0000_0100, 3'b100, 1'b1, 5'd31, 32'h0000_0100, 2'b11};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 3'b000, 1'b0, 5'd31, 32'h0000_0100, 2'b00};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  32'h0000_0000, 1'b1, 5'd0,  32'h0000_0055, 1'b0, 32'h0000_0000, 3'b010, 1'b0, 5'd0,  32'h0000_0055, 2'b10};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b00, 5'd0,  5'd0,  32'h0000_0000, 1'b1, 5'd4,  32'h0000_0066, 1'b0, 32'h0000_0000, 3'b000, 1'b0, 5'd0,  32'h0000_0055, 2'b00};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 2'b01, 5'd3,  5'd9,  32'h0000_0077, 1'b1, 5'd4,  32'h0000_0066, 1'b0, 32'h0000_0000, 3'b010, 1'b1, 5'd4,  32'h0000_0066, 2'b10};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 2'b01, 5'd3,  5'd9,  32'h0000_0077, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 3'b001, 1'b1, 5'd9,  32'h0000_0077, 2'b01};

    @(posedge clock);
    #1;

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      tick();
      chk($sformatf("vec%0d_ack", i),   32'(s_ack),      32'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_we", i),    32'(rf_we),      32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_waddr", i), 32'(rf_waddr),   32'(vecs[i].exp_waddr));
      chk($sformatf("vec%0d_wdata", i), rf_wdata,        vecs[i].exp_wdata);
      chk($sformatf("vec%0d_last", i),  32'(last_grant), 32'(vecs[i].exp_last));
    end

    // starvation: ld and alu requesting every cycle
    idle();
    tick();
    ld_req = 1'b1; ld_addr = 5'd5; ld_data = 32'h0000_5555;
    alu_req = 1'b1; alu_regdst = 2'b01; alu_rd = 5'd9; alu_data = 32'h0000_9999;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("starve_ack%0d", i),  32'(s_ack),      32'(ack_of(starve_seq[i])));
      chk($sformatf("starve_last%0d", i), 32'(last_grant), 32'(starve_seq[i]));
    end
    chk("starve_waddr", 32'(rf_waddr), 32'd5);

    // hold ages lnk to urgent; on release it beats a fresh ld
    idle();
    tick();
    hold = 1'b1; lnk_req = 1'b1; lnk_data = 32'h0000_CAFE;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("hold_ack%0d", i), 32'(s_ack), 32'd0);
      chk($sformatf("hold_we%0d", i),  32'(rf_we), 32'd0);
    end
    hold = 1'b0; ld_req = 1'b1; ld_addr = 5'd6; ld_data = 32'h0000_6666;
    tick();
    chk("hold_release_ack", 32'(s_ack), 32'b100);
    chk("hold_release_we", 32'(rf_we), 32'd1);
    chk("hold_release_waddr", 32'(rf_waddr), 32'd31);
    chk("hold_release_wdata", rf_wdata, 32'h0000_CAFE);
    chk("hold_release_last", 32'(last_grant), 32'd3);
    lnk_req = 1'b0;
    tick();
    chk("hold_then_ld_ack", 32'(s_ack), 32'b010);

    // simultaneous three-way request, each source drops after its ack
    idle();
    tick();
    alu_req = 1'b1; alu_regdst = 2'b00; alu_rt = 5'd12; alu_data = 32'h0000_0A1A;
    ld_req = 1'b1; ld_addr = 5'd13; ld_data = 32'h0000_0B1B;
    lnk_req = 1'b1; lnk_data = 32'h0000_0C1C;
    tick();
    chk("tri0_ack", 32'(s_ack), 32'b010);
    chk("tri0_we", 32'(rf_we), 32'd1);
    chk("tri0_waddr", 32'(rf_waddr), 32'd13);
    ld_req = 1'b0;
    tick();
    chk("tri1_ack", 32'(s_ack), 32'b001);
    chk("tri1_we", 32'(rf_we), 32'd1);
    chk("tri1_waddr", 32'(rf_waddr), 32'd12);
    alu_req = 1'b0;
    tick();
    chk("tri2_ack", 32'(s_ack), 32'b100);
    chk("tri2_we", 32'(rf_we), 32'd1);
    chk("tri2_wdata", rf_wdata, 32'h0000_0C1C);

    // reset mid-operation discards accumulated waiting
    idle();
    tick();
    ld_req = 1'b1; ld_addr = 5'd8; ld_data = 32'h0000_0808;
    lnk_req = 1'b1; lnk_data = 32'h0000_0F0F;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_ack", 32'(s_ack), 32'd0);
    chk("rst_mid_we", 32'(rf_we), 32'd0);
    chk("rst_mid_last", 32'(last_grant), 32'd0);
    chk("rst_mid_waddr", 32'(rf_waddr), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_ld%0d", i), 32'(s_ack), 32'b010);
    end
    tick();
    chk("post_rst_lnk", 32'(s_ack), 32'b100);

    // randomized traffic against the reference model
    idle();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      hold  = ($urandom_range(0, 4) == 0);
      if (alu_req && !s_ack[0]) begin
        if ($urandom_range(0, 9) == 0) alu_req = 1'b0;
      end else begin
        alu_req = 1'($urandom_range(0, 1));
        alu_regdst = 2'($urandom);
        alu_rt = 5'($urandom);
        alu_rd = 5'($urandom);
        alu_data = $urandom;
      end
      if (ld_req && !s_ack[1]) begin
        if ($urandom_range(0, 9) == 0) ld_req = 1'b0;
      end else begin
        ld_req = 1'($urandom_range(0, 1));
        ld_addr = 5'($urandom);
        ld_data = $urandom;
      end
      if (lnk_req && !s_ack[2]) begin
        if ($urandom_range(0, 9) == 0) lnk_req = 1'b0;
      end else begin
        lnk_req = 1'($urandom_range(0, 1));
        lnk_data = $urandom;
      end
      tick();
      chk("rand_ack",   32'(s_ack),      32'(m_ack));
      chk("rand_we",    32'(rf_we),      32'(m_we));
      chk("rand_waddr", 32'(rf_waddr),   32'(m_waddr));
      chk("rand_wdata", rf_wdata,        m_wdata);
      chk("rand_last",  32'(last_grant), 32'(m_last));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
